// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - rectify, attack/release envelope and hysteresis gate detector
// Pipeline: rectify -> envelope -> gate FSM, one sample per clock.
module envelope_follower #(
  parameter int SAMPLE_BITS  = 12,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   sample_valid,
  input  logic [3:0]             a,
  input  logic [3:0]             r,
  input  logic [3:0]             t,
  output logic [7:0]             amplitude,
  output logic                   amplitude_valid,
  output logic                   gate
);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_HOLD} state_t;

  logic [SAMPLE_BITS-1:0] w_neg;
  logic [SAMPLE_BITS-2:0] w_mag;
  logic [7:0]             w_mag8;
  logic [15:0]            w_target;
  logic [15:0]            w_up_shift;
  logic [15:0]            w_dn_shift;
  logic [15:0]            w_up_step;
  logic [15:0]            w_dn_step;
  logic [15:0]            w_env_next;
  logic [7:0]             w_on_level;
  logic [7:0]             w_off_level;

  logic [7:0]  r_mag8;
  logic        r_s1_valid;
  logic [15:0] r_env;
  logic [7:0]  r_amp;
  logic        r_amp_valid;
  state_t      r_state;
  logic [15:0] r_hold_cnt;
  logic        r_gate;

  // Negating the most negative code overflows back to itself; saturate it.
  assign w_neg = ~sample + SAMPLE_BITS'(1);

  always_comb begin
    w_mag = sample[SAMPLE_BITS-2:0];
    if (sample[SAMPLE_BITS-1]) begin
      if (w_neg[SAMPLE_BITS-1]) w_mag = '1;
      else                      w_mag = w_neg[SAMPLE_BITS-2:0];
    end
  end

  assign w_mag8 = w_mag[SAMPLE_BITS-2 -: 8];

  generate
    if (SAMPLE_BITS > 9) begin : g_low_bits
      logic w_unused_low;
      assign w_unused_low = ^w_mag[SAMPLE_BITS-10:0];
    end
  endgenerate

  // Step is a shifted fraction of the distance, floored at 1 so env always converges.
  assign w_target   = {r_mag8, 8'h00};
  assign w_up_shift = (w_target - r_env) >> a;
  assign w_dn_shift = (r_env - w_target) >> r;
  assign w_up_step  = (w_up_shift == 16'd0) ? 16'd1 : w_up_shift;
  assign w_dn_step  = (w_dn_shift == 16'd0) ? 16'd1 : w_dn_shift;

  always_comb begin
    w_env_next = r_env;
    if (w_target > r_env)      w_env_next = r_env + w_up_step;
    else if (w_target < r_env) w_env_next = r_env - w_dn_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag8      <= 8'd0;
      r_s1_valid  <= 1'b0;
      r_env       <= 16'd0;
      r_amp       <= 8'd0;
      r_amp_valid <= 1'b0;
    end else begin
      r_s1_valid  <= sample_valid;
      r_amp_valid <= r_s1_valid;
      if (sample_valid) r_mag8 <= w_mag8;
      if (r_s1_valid) begin
        r_env <= w_env_next;
        r_amp <= w_env_next[15:8];
      end
    end
  end

  assign w_on_level  = {t, 4'h0};
  assign w_off_level = {1'b0, t, 3'b000};

  // Gate FSM only moves on a fresh amplitude; between levels counts toward hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= 16'd0;
      r_gate     <= 1'b0;
    end else if (r_amp_valid) begin
      if (t == 4'd0) begin
        r_state <= S_IDLE;
        r_gate  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_amp >= w_on_level) begin
              r_state <= S_OPEN;
              r_gate  <= 1'b1;
            end
          end
          S_OPEN: begin
            if (r_amp < w_off_level) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= 16'd1;
            end
          end
          S_HOLD: begin
            if (r_amp >= w_on_level) begin
              r_state <= S_OPEN;
            end else if (r_hold_cnt == 16'(HOLD_SAMPLES)) begin
              r_state <= S_IDLE;
              r_gate  <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 16'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_gate  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign amplitude       = r_amp;
  assign amplitude_valid = r_amp_valid;
  assign gate            = r_gate;

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - scoreboard bench for envelope_follower
module tb_envelope_follower;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample;
  logic        sample_valid;
  logic [3:0]  a;
  logic [3:0]  r;
  logic [3:0]  t;
  logic [7:0]  amplitude;
  logic        amplitude_valid;
  logic        gate;

  always #5 clk = ~clk;

  envelope_follower #(.SAMPLE_BITS(12), .HOLD_SAMPLES(HOLD)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .a(a), .r(r), .t(t),
    .amplitude(amplitude), .amplitude_valid(amplitude_valid), .gate(gate)
  );

  typedef struct {
    int amp;
    int gate;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_env = 0;
  int   m_st = 0;
  int   m_hold = 0;
  bit   gate_pend = 0;
  int   gate_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference envelope and gate behaviour, advanced once per accepted sample.
  task automatic model_step(input int s);
    int mag;
    int step;
    int amp;
    mag = (s < 0) ? -s : s;
    if (mag > 2047) mag = 2047;
    mag = (mag >> 3) << 8;
    if (mag > m_env) begin
      step = (mag - m_env) >> a;
      if (step == 0) step = 1;
      m_env = m_env + step;
    end else if (mag < m_env) begin
      step = (m_env - mag) >> r;
      if (step == 0) step = 1;
      m_env = m_env - step;
    end
    amp = m_env >> 8;
    if (t == 0) m_st = 0;
    else if (m_st == 0) begin
      if (amp >= t * 16) m_st = 1;
    end else if (m_st == 1) begin
      if (amp < t * 8) begin m_st = 2; m_hold = 1; end
    end else begin
      if (amp >= t * 16) m_st = 1;
      else if (m_hold == HOLD) m_st = 0;
      else m_hold++;
    end
  endtask

  task automatic send(input int s);
    exp_t e;
    sample       = 12'(s);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    model_step(s);
    e.amp  = m_env >> 8;
    e.gate = (m_st != 0) ? 1 : 0;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !gate_pend) return;
      @(negedge clk);
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (gate_pend) begin
        chk("gate", gate, gate_exp);
        gate_pend = 0;
      end
      if (amplitude_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", amplitude_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("amplitude", amplitude, e.amp);
          chk("latency", cyc, e.cyc);
          gate_exp  = e.gate;
          gate_pend = 1;
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; sample = '0; sample_valid = 1'b0; a = 4'd0; r = 4'd0; t = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_amp", amplitude, 0);
    chk("reset_valid", amplitude_valid, 0);
    chk("reset_gate", gate, 0);

    // Instant attack/release and rectifier saturation.
    send(2047); drain();
    send(0);
    send(-2048);
    send(-100);
    send(0); drain();

    // Exponential attack converges exactly to 0xFF00.
    a = 4'd4;
    for (int i = 0; i < 160; i++) send(2047);
    drain();
    chk("attack_final", amplitude, 255);

    // Release floor step of 1 from full scale, then from a small level down to zero.
    a = 4'd0; r = 4'd0;
    send(2047); drain();
    r = 4'd15;
    for (int i = 0; i < 600; i++) send(0);
    drain();
    chk("release_partial", amplitude, 252);
    r = 4'd0;
    send(8); drain();
    r = 4'd15;
    for (int i = 0; i < 300; i++) send(0);
    drain();
    chk("release_zero", amplitude, 0);

    // Gate hysteresis and hold.
    r = 4'd0; t = 4'd8;
    send(1024); drain();
    send(800);
    for (int i = 0; i < 5; i++) begin
      send(400);
      repeat (i % 2) @(posedge clk);
      #1;
    end
    drain();
    chk("gate_closed", gate, 0);
    send(1024);
    send(400);
    send(400);
    send(1040); drain();
    chk("gate_reopened", gate, 1);
    for (int i = 0; i < 5; i++) send(400);
    drain();

    // Gate disable.
    t = 4'd0;
    send(2047); drain();
    t = 4'd8;
    send(2047); drain();
    chk("gate_open_pre_disable", gate, 1);
    t = 4'd0;
    send(2047); drain();
    t = 4'd8;

    // Reset in the middle of back-to-back samples.
    send(2047);
    send(2047);
    send(2047);
    chk("pre_reset_gate", gate, 1);
    rst = 1'b1; sample = 12'd2047; sample_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; sample_valid = 1'b0;
    sb.delete();
    gate_pend = 0;
    m_env = 0; m_st = 0; m_hold = 0;
    chk("midreset_amp", amplitude, 0);
    chk("midreset_valid", amplitude_valid, 0);
    chk("midreset_gate", gate, 0);
    repeat (3) @(posedge clk);
    #1;
    a = 4'd4;
    send(2047); drain();
    chk("cold_start_amp", amplitude, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
